// File: rtl/control_fsm.sv
// -----------------------------------------------------------------------------
// control_fsm
//
// Multi-cycle control unit with a built-in step sequencer. It captures the
// instruction at the current PC into an internal IR during FETCH, then walks
// T1 -> T2 -> T3 and drives the datapath strobes (GPR file, A/R registers,
// ALU, output bus, PC). The instruction set is ADD/SUB/NAND/OUT/LDI/BNE/REP/
// BEQ/JMP/HALT. Any other opcode raises a sticky illegal flag and then
// executes as a NOP that still advances the PC.
//
// Ports
//   clock_i        in   1        system clock, rising edge
//   resetn_i       in   1        asynchronous active-low reset
//   run_i          in   1        start / continue execution
//   instr_in_i     in   INSTR_W  instruction at current PC
//   mux_out_i      in   DATA_W   datapath bus value (branch test in T3)
//   ir_load_o      out  1        IR captures instr_in_i this cycle
//   op_select_o    out  3        ALU op: 000 ADD, 001 SUB, 010 NAND, 111 pass
//   sel_reg_o      out  RW+1     bus source: 0..NREG-1 GPR, NREG imm, NREG+1 R
//   a_enable_o     out  1        load A register
//   r_enable_o     out  1        load R register
//   reg_enable_o   out  NREG     one-hot GPR write enable (writeback only)
//   bus_enable_o   out  1        drive output port
//   pc_enable_o    out  1        update PC this cycle
//   pc_load_o      out  1        1 = PC loads branch target, 0 = PC+1
//   step_o         out  2        current step (FETCH=00..T3=11), debug view
//   done_o         out  1        one-cycle pulse in T3 of each instruction
//   halted_o       out  1        sticky, HALT executed
//   illegal_o      out  1        sticky, undefined opcode seen
//
// Handshake: run_i is a level, not a valid/ready pair. It is looked at only
// while idle and in T3; once an instruction has started it always runs to
// its end, whatever run_i does in the meantime.
// -----------------------------------------------------------------------------
module control_fsm #(
    parameter int INSTR_W = 16,
    parameter int DATA_W  = 16,
    parameter int NREG    = 8,
    localparam int RW     = $clog2(NREG)
) (
    input  logic               clock_i,
    input  logic               resetn_i,
    input  logic               run_i,
    input  logic [INSTR_W-1:0] instr_in_i,
    input  logic [DATA_W-1:0]  mux_out_i,
    output logic               ir_load_o,
    output logic [2:0]         op_select_o,
    output logic [RW:0]        sel_reg_o,
    output logic               a_enable_o,
    output logic               r_enable_o,
    output logic [NREG-1:0]    reg_enable_o,
    output logic               bus_enable_o,
    output logic               pc_enable_o,
    output logic               pc_load_o,
    output logic [1:0]         step_o,
    output logic               done_o,
    output logic               halted_o,
    output logic               illegal_o
);

    // Opcode map
    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_NAND = 4'h2;
    localparam logic [3:0] OP_OUT  = 4'h4;
    localparam logic [3:0] OP_LDI  = 4'h5;
    localparam logic [3:0] OP_BNE  = 4'h6;
    localparam logic [3:0] OP_REP  = 4'h7;
    localparam logic [3:0] OP_BEQ  = 4'h8;
    localparam logic [3:0] OP_JMP  = 4'h9;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam logic [2:0] ALU_PASS = 3'b111;

    // Bus source codes beyond the GPRs: immediate and the R register
    localparam int          SEL_R_INT = NREG + 1;
    localparam logic [RW:0] SEL_IMM   = NREG[RW:0];
    localparam logic [RW:0] SEL_R     = SEL_R_INT[RW:0];

    localparam logic [NREG-1:0] REG_ONE = {{(NREG-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_T1     = 3'd2,
        S_T2     = 3'd3,
        S_T3     = 3'd4,
        S_HALTED = 3'd5
    } state_e;

    state_e             state_q, state_d;
    logic [INSTR_W-1:0] ir_q, ir_d;
    logic               illegal_q, illegal_d;

    // Decode always works from the latched IR so that instr_in_i may change
    // freely once FETCH is over.
    logic [3:0]    opcode;
    logic [RW-1:0] rx;
    logic [RW-1:0] ry;
    logic [RW:0]   sel_rx;
    logic [RW:0]   sel_ry;
    logic          is_alu;
    logic          is_legal;
    logic          ir_unused;

    assign opcode = ir_q[INSTR_W-1 -: 4];
    assign rx     = ir_q[INSTR_W-5 -: RW];
    assign ry     = ir_q[INSTR_W-5-RW -: RW];
    assign sel_rx = {1'b0, rx};
    assign sel_ry = {1'b0, ry};
    assign is_alu = (opcode == OP_ADD) || (opcode == OP_SUB) || (opcode == OP_NAND);

    // The low IR bits carry no field for this encoding; fold them so that
    // the whole register is visibly consumed.
    assign ir_unused = ^ir_q;

    always_comb begin
        is_legal = 1'b0;
        case (opcode)
            OP_ADD, OP_SUB, OP_NAND, OP_OUT, OP_LDI,
            OP_BNE, OP_REP, OP_BEQ, OP_JMP, OP_HALT: is_legal = 1'b1;
            default:                                 is_legal = 1'b0;
        endcase
    end

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clock_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q   <= S_IDLE;
            ir_q      <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            illegal_q <= illegal_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next state and datapath strobes
    // -------------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        ir_d         = ir_q;
        illegal_d    = illegal_q;
        ir_load_o    = 1'b0;
        op_select_o  = 3'b000;
        sel_reg_o    = '0;
        a_enable_o   = 1'b0;
        r_enable_o   = 1'b0;
        reg_enable_o = '0;
        bus_enable_o = 1'b0;
        pc_enable_o  = 1'b0;
        pc_load_o    = 1'b0;
        step_o       = 2'b00;
        done_o       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (run_i) begin
                    state_d = S_FETCH;
                end
            end

            S_FETCH: begin
                step_o    = 2'b00;
                ir_load_o = 1'b1;
                ir_d      = instr_in_i;
                state_d   = S_T1;
            end

            S_T1: begin
                step_o  = 2'b01;
                state_d = S_T2;
                if (is_alu) begin
                    sel_reg_o  = sel_rx;
                    a_enable_o = 1'b1;
                end else if ((opcode == OP_OUT) || (opcode == OP_BNE) ||
                             (opcode == OP_BEQ)) begin
                    sel_reg_o = sel_rx;
                end else if (opcode == OP_HALT) begin
                    state_d = S_HALTED;
                end
                if (!is_legal) begin
                    illegal_d = 1'b1;
                end
            end

            S_T2: begin
                step_o  = 2'b10;
                state_d = S_T3;
                if (is_alu) begin
                    sel_reg_o   = sel_ry;
                    op_select_o = opcode[2:0];
                    r_enable_o  = 1'b1;
                end else if (opcode == OP_REP) begin
                    sel_reg_o   = sel_ry;
                    op_select_o = ALU_PASS;
                    r_enable_o  = 1'b1;
                end else if (opcode == OP_LDI) begin
                    sel_reg_o   = SEL_IMM;
                    op_select_o = ALU_PASS;
                    r_enable_o  = 1'b1;
                end else if (opcode == OP_OUT) begin
                    sel_reg_o    = sel_rx;
                    bus_enable_o = 1'b1;
                end else if ((opcode == OP_BNE) || (opcode == OP_BEQ)) begin
                    sel_reg_o = sel_rx;
                end
            end

            S_T3: begin
                // HALT never reaches T3, so every instruction seen here
                // retires and advances the PC.
                step_o      = 2'b11;
                pc_enable_o = 1'b1;
                done_o      = 1'b1;
                state_d     = run_i ? S_FETCH : S_IDLE;
                if (is_alu || (opcode == OP_REP) || (opcode == OP_LDI)) begin
                    reg_enable_o = REG_ONE << rx;
                    sel_reg_o    = SEL_R;
                end else if (opcode == OP_OUT) begin
                    sel_reg_o    = sel_rx;
                    bus_enable_o = 1'b1;
                end else if (opcode == OP_BNE) begin
                    // RX is on the bus, so the branch test sees its value
                    // in this same cycle.
                    sel_reg_o = sel_rx;
                    pc_load_o = (mux_out_i != '0);
                end else if (opcode == OP_BEQ) begin
                    sel_reg_o = sel_rx;
                    pc_load_o = (mux_out_i == '0);
                end else if (opcode == OP_JMP) begin
                    pc_load_o = 1'b1;
                end
            end

            S_HALTED: begin
                state_d = S_HALTED;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign halted_o = (state_q == S_HALTED);

    // The flag is raised while the offending instruction is still in T1,
    // then held by the sticky register until reset.
    assign illegal_o = illegal_q || ((state_q == S_T1) && !is_legal);

endmodule
